// File: rtl/pixel_window_sequencer.sv
// Walks a 3x3 window across a frame: nine pixel reads, one gradient
// request and one result write per window position.
module pixel_window_sequencer #(
    parameter int ADDR_W = 20,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              load_en,
    output logic [3:0]        pix_idx,
    output logic              start_grad,
    input  logic              grad_done,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic              busy,
    output logic              all_done
);

    typedef enum logic [2:0] {
        IDLE, LATCH, RD, CALC, CALC_WAIT, WRITE, ADVANCE, DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]  w_q, h_q, row, col;
    logic [ADDR_W-1:0] rd_base_q, wr_base_q;
    logic [ADDR_W-1:0] win_addr, line_addr, wr_ptr;
    logic [3:0]        pix;
    logic [1:0]        dx;
    logic              too_small, last_col, last_win;

    assign too_small = (w_q < DIM_W'(3)) || (h_q < DIM_W'(3));
    assign last_col  = (col == w_q - DIM_W'(3));
    assign last_win  = last_col && (row == h_q - DIM_W'(3));

    always_comb begin
        state_nxt  = state;
        rd_req     = 1'b0;
        rd_addr    = '0;
        load_en    = 1'b0;
        start_grad = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        all_done   = 1'b0;
        busy       = (state != IDLE);
        pix_idx    = pix;
        unique case (state)
            IDLE:    if (start) state_nxt = LATCH;
            LATCH:   state_nxt = too_small ? DONE : RD;
            RD: begin
                rd_req  = 1'b1;
                rd_addr = line_addr + ADDR_W'(dx);
                load_en = rd_ack;
                if (rd_ack && pix == 4'd8) state_nxt = CALC;
            end
            CALC: begin
                start_grad = 1'b1;
                state_nxt  = CALC_WAIT;
            end
            CALC_WAIT: if (grad_done) state_nxt = WRITE;
            WRITE: begin
                wr_req  = 1'b1;
                wr_addr = wr_ptr;
                if (wr_ack) state_nxt = ADVANCE;
            end
            ADVANCE: state_nxt = last_win ? DONE : RD;
            DONE: begin
                all_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // line_addr tracks rd_base + (row+dy)*W + col; stepping to the next
    // window row from the last column is +3 (W - (W-3)).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            row       <= '0;
            col       <= '0;
            pix       <= '0;
            dx        <= '0;
            win_addr  <= '0;
            line_addr <= '0;
            wr_ptr    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w_q       <= img_width;
                        h_q       <= img_height;
                        rd_base_q <= rd_base;
                        wr_base_q <= wr_base;
                    end
                end
                LATCH: begin
                    row       <= '0;
                    col       <= '0;
                    pix       <= '0;
                    dx        <= '0;
                    win_addr  <= rd_base_q;
                    line_addr <= rd_base_q;
                    wr_ptr    <= wr_base_q;
                end
                RD: begin
                    if (rd_ack) begin
                        if (pix == 4'd8) begin
                            pix       <= '0;
                            dx        <= '0;
                            line_addr <= win_addr;
                        end else begin
                            pix <= pix + 4'd1;
                            if (dx == 2'd2) begin
                                dx        <= '0;
                                line_addr <= line_addr + ADDR_W'(w_q);
                            end else begin
                                dx <= dx + 2'd1;
                            end
                        end
                    end
                end
                ADVANCE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (last_col) begin
                        col       <= '0;
                        row       <= row + DIM_W'(1);
                        win_addr  <= win_addr + ADDR_W'(3);
                        line_addr <= win_addr + ADDR_W'(3);
                    end else begin
                        col       <= col + DIM_W'(1);
                        win_addr  <= win_addr + ADDR_W'(1);
                        line_addr <= win_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_window_sequencer.sv
// Bench for pixel_window_sequencer: directed frames plus randomized
// handshake timing, checked against a nested-loop address model.
module tb_pixel_window_sequencer;

    localparam int AW = 20;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [DW-1:0] img_width, img_height;
    logic [AW-1:0] rd_base, wr_base;
    logic          rd_req, rd_ack, load_en, start_grad, grad_done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    pix_idx;
    logic          wr_req, wr_ack, busy, all_done;

    int tests = 0;
    int fails = 0;

    pixel_window_sequencer #(.ADDR_W(AW), .DIM_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .rd_base(rd_base), .wr_base(wr_base),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .load_en(load_en), .pix_idx(pix_idx),
        .start_grad(start_grad), .grad_done(grad_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .busy(busy), .all_done(all_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_rd_req"},   rd_req, 0);
        chk({tag, "_wr_req"},   wr_req, 0);
        chk({tag, "_rd_addr"},  rd_addr, 0);
        chk({tag, "_wr_addr"},  wr_addr, 0);
        chk({tag, "_pix_idx"},  pix_idx, 0);
        chk({tag, "_load_en"},  load_en, 0);
        chk({tag, "_sgrad"},    start_grad, 0);
        chk({tag, "_all_done"}, all_done, 0);
    endtask

    task automatic run_frame(input int w, input int h,
                             input int rb, input int wb,
                             input int rlo, input int rhi,
                             input int wlo, input int whi,
                             input bit poke);
        logic [AW-1:0] er[$];
        logic [AW-1:0] ew[$];
        int rd_n = 0, wr_n = 0, sg = 0, ad = 0, cyc = 0;
        int rw, ww, gcnt = 0;
        bit gpend = 0, both = 0, poked = 0, fin = 0;
        for (int r = 0; r <= h - 3; r++)
            for (int c = 0; c <= w - 3; c++) begin
                for (int p = 0; p < 9; p++)
                    er.push_back(AW'(rb + (r + p / 3) * w + c + p % 3));
                ew.push_back(AW'(wb + r * (w - 2) + c));
            end
        rw = $urandom_range(rhi, rlo);
        ww = $urandom_range(whi, wlo);
        @(negedge clk);
        img_width  = DW'(w);
        img_height = DW'(h);
        rd_base    = AW'(rb);
        wr_base    = AW'(wb);
        start      = 1'b1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            grad_done = 1'b0;
            if (poke && !poked && gpend) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (rd_req && wr_req) both = 1'b1;
            if (gpend) begin
                if (gcnt == 0) begin
                    grad_done = 1'b1;
                    gpend     = 1'b0;
                end else gcnt--;
            end
            if (start_grad) begin
                sg++;
                chk("grad_after_9_loads", rd_n, 9 * (wr_n + 1));
                gpend = 1'b1;
                gcnt  = $urandom_range(2, 0);
            end
            if (rd_req) begin
                if (rd_n < er.size()) chk("rd_addr", rd_addr, er[rd_n]);
                else chk("extra_rd", rd_n, er.size());
                chk("pix_idx", pix_idx, rd_n % 9);
                if (rw == 0) begin
                    rd_ack = 1'b1;
                    #1 chk("load_en", load_en, 1);
                    rd_n++;
                    rw = $urandom_range(rhi, rlo);
                end else begin
                    rd_ack = 1'b0;
                    rw--;
                    #1 chk("load_en_wait", load_en, 0);
                end
            end else begin
                rd_ack = 1'($urandom_range(1, 0));
            end
            if (wr_req) begin
                if (wr_n < ew.size()) chk("wr_addr", wr_addr, ew[wr_n]);
                else chk("extra_wr", wr_n, ew.size());
                if (ww == 0) begin
                    wr_ack = 1'b1;
                    wr_n++;
                    ww = $urandom_range(whi, wlo);
                end else begin
                    wr_ack = 1'b0;
                    ww--;
                end
            end else begin
                wr_ack = 1'($urandom_range(1, 0));
            end
            if (all_done) begin
                ad++;
                fin = 1'b1;
            end
        end
        chk("frame_timeout", fin, 1);
        chk("rd_count", rd_n, er.size());
        chk("wr_count", wr_n, ew.size());
        chk("start_grad_count", sg, ew.size());
        chk("all_done_count", ad, 1);
        chk("rd_wr_overlap", both, 0);
        if (w < 3 || h < 3) chk("degenerate_done_cycle", cyc, 2);
        if (poke) chk("start_poked", poked, 1);
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        grad_done = 1'b0;
        @(negedge clk);
        chk("after_busy", busy, 0);
        chk("after_all_done", all_done, 0);
        @(negedge clk);
        chk("after2_busy", busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        img_width  = '0;
        img_height = '0;
        rd_base    = '0;
        wr_base    = '0;
        rd_ack     = 1'b0;
        grad_done  = 1'b0;
        wr_ack     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        run_frame(3, 3, 'h100, 'h800, 0, 0, 0, 0, 0);
        run_frame(4, 3, 0, 'h400, 0, 0, 0, 0, 0);
        run_frame(3, 3, 'h100, 'h800, 3, 3, 2, 2, 0);
        run_frame(2, 5, 'h100, 'h800, 0, 0, 0, 0, 0);
        run_frame(5, 2, 'h100, 'h800, 0, 0, 0, 0, 0);
        run_frame(4, 4, 'h300, 'h900, 0, 1, 0, 1, 1);

        @(negedge clk);
        img_width  = DW'(3);
        img_height = DW'(3);
        rd_base    = AW'('h200);
        wr_base    = AW'('h600);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !(rd_req && pix_idx == 4'd4); i++) begin
            rd_ack = rd_req;
            @(negedge clk);
        end
        rd_ack = 1'b0;
        chk("mid_rd_req", rd_req, 1);
        chk("mid_pix_idx", pix_idx, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrst");
        run_frame(3, 4, 'h200, 'h600, 0, 1, 0, 1, 0);

        run_frame(5, 4, 'hFFFF8, 'hFFFFE, 0, 2, 0, 2, 0);
        repeat (6) begin
            run_frame($urandom_range(8, 3), $urandom_range(6, 3),
                      int'($urandom_range(20'hFFFFF, 0)),
                      int'($urandom_range(20'hFFFFF, 0)),
                      0, 2, 0, 2, 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_window_sequencer.md
PIXEL_WINDOW_SEQUENCER -- requirements
Module: pixel_window_sequencer

Interface
REQ-001 Parameter ADDR_W, default 20: width of the read and write memory addresses.
REQ-002 Parameter DIM_W, default 10: width of the image width and height inputs.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  begin one frame; sampled only in IDLE.
REQ-006 img_width, img_height  input  DIM_W each  source image size in pixels; latched on start.
REQ-007 rd_base, wr_base  input  ADDR_W each  source and result base addresses; latched on start.
REQ-008 rd_req / rd_addr  output  1 / ADDR_W  read request with pixel address.
REQ-009 rd_ack  input  1  read accepted; read data valid in the same cycle.
REQ-010 load_en / pix_idx  output  1 / 4  write strobe and slot (0..8) for the 3x3 window register.
REQ-011 start_grad  output  1  one-cycle pulse that starts the gradient calculation.
REQ-012 grad_done  input  1  gradient result ready.
REQ-013 wr_req / wr_addr  output  1 / ADDR_W  result write request with address.
REQ-014 wr_ack  input  1  write accepted.
REQ-015 busy / all_done  output  1 / 1  frame in progress / one-cycle pulse at end of frame.

Function
REQ-016 The state machine SHALL have the states IDLE, LATCH, RD, CALC, CALC_WAIT, WRITE, ADVANCE and DONE.
REQ-017 IDLE SHALL go to LATCH on start=1; start SHALL be ignored in every other state.
REQ-018 LATCH SHALL register all configuration inputs and clear row, col and pix_idx; it SHALL go to DONE if the latched width < 3 or height < 3, and to RD otherwise.
REQ-019 RD SHALL drive rd_req=1 with rd_addr = rd_base + (row+dy)*W + (col+dx), where dy = pix_idx/3 and dx = pix_idx%3.
REQ-020 rd_addr SHALL stay stable until rd_ack is sampled high.
REQ-021 The (row+dy)*W term SHALL be generated from an incrementally updated row-base register; no multiplier.
REQ-022 In each rd_ack cycle the block SHALL drive load_en=1 with the current pix_idx, then increment pix_idx; the ack of pix_idx 8 SHALL go to CALC with pix_idx cleared.
REQ-023 CALC SHALL pulse start_grad for exactly one cycle, then go to CALC_WAIT.
REQ-024 CALC_WAIT SHALL hold until grad_done=1, then go to WRITE.
REQ-025 WRITE SHALL drive wr_req=1 with wr_addr = wr_base + row*(W-2) + col, stable until wr_ack, then go to ADVANCE.
REQ-026 ADVANCE: if col < W-3, col SHALL increment; otherwise col SHALL become 0 and row SHALL increment. If the window just written was row = H-3 and col = W-3, the next state SHALL be DONE; otherwise it SHALL be RD.
REQ-027 DONE SHALL pulse all_done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W with no overflow flag.
REQ-030 rd_ack outside RD and wr_ack outside WRITE SHALL be ignored.
REQ-031 rd_req and wr_req SHALL never be asserted in the same cycle.

Reset
REQ-032 With rst=1 at a clock edge the block SHALL enter IDLE from any state, including mid-request.
REQ-033 That reset SHALL force all outputs to 0 (rd_addr=0, wr_addr=0, pix_idx=0) and clear row, col and the latched configuration.
REQ-034 An outstanding handshake aborted by reset SHALL not be resumed.

Verification
REQ-035 W=3, H=3, rd_base=0x100, wr_base=0x800, rd_ack always 1 -> rd_addr 0x100..0x108 in order; pix_idx 0..8; one start_grad; after grad_done, one write to 0x800; one all_done.
REQ-036 W=4, H=3, rd_base=0 -> window 0 reads 0,1,2,4,5,6,8,9,10; window 1 reads 1,2,3,5,6,7,9,10,11; writes to wr_base+0 then wr_base+1; then all_done.
REQ-037 W=3, H=3, rd_ack delayed 3 cycles per read and wr_ack delayed 2 cycles -> rd_addr/wr_addr stable while requested; exactly 9 load_en pulses; start_grad held off until the 9th ack.
REQ-038 W=2, H=5 -> no rd_req or wr_req; all_done pulses 2 cycles after start; back in IDLE.
REQ-039 rst=1 while waiting in RD with pix_idx=4 -> next cycle: IDLE, all outputs 0; a new start restarts at pix_idx 0, rd_addr=rd_base.
REQ-040 start=1 pulsed during CALC_WAIT -> ignored; the frame completes with exactly one all_done.
